// File: rtl/core_pkg.sv
// Shared RV32I core types: immediate-format select and machine word.
package core_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_J = 2'd3
  } imm_src_t;

  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/imm_extend_comb.sv
// Pure combinational immediate format mux for I/S/B/J.
// The port carries instr[31:7], so full-instruction bit n is instr[n-7] here.
module imm_extend_comb
  import core_pkg::*;
(
  input  imm_src_t    imm_src,
  input  logic [24:0] instr,
  output word_t       imm_ext
);

  always_comb begin
    imm_ext = {{20{instr[24]}}, instr[24:13]};
    case (imm_src)
      IMM_I: imm_ext = {{20{instr[24]}}, instr[24:13]};
      IMM_S: imm_ext = {{20{instr[24]}}, instr[24:18], instr[4:0]};
      IMM_B: imm_ext = {{20{instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
      IMM_J: imm_ext = {{12{instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
      default: imm_ext = {{20{instr[24]}}, instr[24:13]};
    endcase
  end

endmodule

// File: rtl/imm_extend.sv
// RV32I immediate generator: combinational result plus a one-stage
// registered copy with valid for the decode->execute pipeline boundary.
module imm_extend
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      imm_src,
  input  logic [24:0]     instr,
  input  logic            in_valid,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] imm_ext_q,
  output logic            out_valid
);

  word_t imm_comb;
  word_t imm_d, imm_q;
  logic  vld_d, vld_q;

  imm_extend_comb u_comb (
    .imm_src (imm_src_t'(imm_src)),
    .instr   (instr),
    .imm_ext (imm_comb)
  );

  // Hold the last captured immediate when the slot is empty.
  always_comb begin
    imm_d = imm_q;
    vld_d = in_valid;
    if (in_valid) imm_d = imm_comb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q <= '0;
      vld_q <= 1'b0;
    end else begin
      imm_q <= imm_d;
      vld_q <= vld_d;
    end
  end

  assign imm_ext   = imm_comb;
  assign imm_ext_q = imm_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_imm_extend.sv
// Directed bench for imm_extend with a scoreboard queue on the registered path.
module tb_imm_extend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  imm_src;
  logic [24:0] instr;
  logic        in_valid;
  logic [31:0] imm_ext, imm_ext_q;
  logic        out_valid;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_q;

  imm_extend #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imm_src   (imm_src),
    .instr     (instr),
    .in_valid  (in_valid),
    .imm_ext   (imm_ext),
    .imm_ext_q (imm_ext_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent reference written bit-by-bit from the full instruction word.
  function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [1:0] s);
    logic [31:0] r;
    r = '0;
    case (s)
      2'd0: begin r[11:0] = i[31:20]; for (int k = 12; k < 32; k++) r[k] = i[31]; end
      2'd1: begin r[11:5] = i[31:25]; r[4:0] = i[11:7]; for (int k = 12; k < 32; k++) r[k] = i[31]; end
      2'd2: begin r[12] = i[31]; r[11] = i[7]; r[10:5] = i[30:25]; r[4:1] = i[11:8];
                  for (int k = 13; k < 32; k++) r[k] = i[31]; end
      default: begin r[20] = i[31]; r[19:12] = i[19:12]; r[11] = i[20]; r[10:1] = i[30:21];
                  for (int k = 21; k < 32; k++) r[k] = i[31]; end
    endcase
    return r;
  endfunction

  // Drive one cycle at negedge, check comb output, then check the registered
  // side one edge later against the scoreboard.
  task automatic cyc(input string tag, input logic [31:0] full, input logic [1:0] src,
                     input logic v, input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clk);
    instr = full[31:7]; imm_src = src; in_valid = v;
    #1 chk({tag, "_comb"}, imm_ext, exp);
    if (v) sb_q.push_back(exp);
    @(posedge clk);
    #1 chk({tag, "_vld"}, {31'd0, out_valid}, {31'd0, v});
    if (out_valid) begin
      if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk({tag, "_q"}, imm_ext_q, e);
        last_q = e;
      end
    end else begin
      chk({tag, "_hold"}, imm_ext_q, last_q);
    end
  endtask

  logic [31:0] ri;
  logic [1:0]  rs;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; imm_src = 2'd0; instr = '0; last_q = '0;
    #12;
    chk("rst_q", imm_ext_q, 32'h0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    cyc("i_pos",  32'h00100093, 2'd0, 1'b1, 32'h00000001);
    cyc("i_neg",  32'hFFF00093, 2'd0, 1'b1, 32'hFFFFFFFF);
    cyc("i_zero", 32'h00000013, 2'd0, 1'b1, 32'h00000000);
    cyc("s_pos",  32'h7E002D23, 2'd1, 1'b1, 32'h000007FA);
    cyc("s_neg",  32'hFE002D23, 2'd1, 1'b1, 32'hFFFFFFFA);
    cyc("b_pos",  32'h00000463, 2'd2, 1'b1, 32'h00000008);
    cyc("b_neg",  32'hFE000EE3, 2'd2, 1'b1, 32'hFFFFFFFC);
    cyc("j_pos",  32'h7E60006F, 2'd3, 1'b1, 32'h000007E6);
    cyc("j_neg",  32'hFE3FF06F, 2'd3, 1'b1, 32'hFFFFFFE2);
    // in_valid low: comb still live, register holds
    cyc("idle0",  32'h00100093, 2'd0, 1'b0, 32'h00000001);
    cyc("idle1",  32'h7E002D23, 2'd1, 1'b0, 32'h000007FA);

    for (int n = 0; n < 12; n++) begin
      ri = $urandom; rs = 2'($urandom_range(3));
      cyc("rand", ri, rs, 1'((n % 3) != 2), ref_imm(ri, rs));
    end

    // Asynchronous reset mid-stream, between edges
    @(negedge clk);
    instr = 32'hFE3FF06F >> 7; imm_src = 2'd3; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("arst_q", imm_ext_q, 32'h0);
    chk("arst_vld", {31'd0, out_valid}, 32'd0);
    chk("arst_comb", imm_ext, 32'hFFFFFFE2);
    instr = 32'h00000463 >> 7; imm_src = 2'd2;
    #1 chk("arst_comb2", imm_ext, 32'h00000008);
    sb_q.delete(); last_q = '0;
    @(posedge clk);
    #1 chk("arst_hold_q", imm_ext_q, 32'h0);
    chk("arst_hold_vld", {31'd0, out_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    cyc("post_j", 32'h7E60006F, 2'd3, 1'b1, 32'h000007E6);
    cyc("post_s", 32'hFE002D23, 2'd1, 1'b1, 32'hFFFFFFFA);
    cyc("post_idle", 32'h00000013, 2'd0, 1'b0, 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
